radio_config: RTL and testbench
===============================

RADIO_CONFIG -- requirements
Module: radio_config

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk16 cycles (range 1..255).
REQ-002 SHALL have parameter NUM_WORDS, default 10: boot table length (range 1..16).
REQ-003 SHALL have parameter GAP_CYCLES, default 16: CSn-high cycles after each frame (range 1..255).
REQ-004 SHALL have port clk16 input 1: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst input 1: asynchronous, active-high reset.
REQ-006 SHALL have port start_i input 1: one-cycle pulse requesting the boot sequence.
REQ-007 SHALL have ports wr_valid_i input 1, wr_addr_i input 4, wr_data_i input 28: host single-register write request.
REQ-008 SHALL have port wr_ready_o output 1: host write is accepted when wr_valid_i and wr_ready_o are both high.
REQ-009 SHALL have ports spi_sclk_o, spi_sdata_o and spi_csn_o, output 1 each: MAX2769 3-wire bus.
REQ-010 SHALL have port radio_en_o output 1: drives the MAX2769 SHDN/IDLE enable.
REQ-011 SHALL have ports busy_o output 1, done_o output 1 and cfg_idx_o output 4: status and current boot index.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, SHIFT, GAP and DONE.
REQ-013 SHALL, on start_i in IDLE or DONE, clear done_o and radio_en_o, set cfg_idx_o=0 and enter LOAD next cycle.
REQ-014 SHALL ignore start_i in LOAD, SHIFT and GAP.
REQ-015 SHALL drive wr_ready_o = (state is IDLE or DONE) AND NOT start_i; start_i has priority over a host write in the same cycle.
REQ-016 SHALL, on an accepted host write, capture {wr_data_i, wr_addr_i} and enter LOAD; cfg_idx_o and radio_en_o stay unchanged.
REQ-017 SHALL, in LOAD (1 cycle), form a 32-bit frame {data[27:0], addr[3:0]}; boot frames take address = cfg_idx_o and data = package table entry cfg_idx_o.
REQ-018 SHALL assert spi_csn_o low on entry to SHIFT and present the frame MSB first on spi_sdata_o.
REQ-019 SHALL, per bit, hold spi_sclk_o low for CLK_DIV cycles, then high for CLK_DIV cycles; spi_sdata_o changes only while spi_sclk_o is low.
REQ-020 SHALL leave SHIFT after exactly 32 bits (64*CLK_DIV cycles), then raise spi_csn_o, hold spi_sclk_o low, and enter GAP.
REQ-021 SHALL stay in GAP for GAP_CYCLES cycles; one frame thus occupies 1 + 64*CLK_DIV + GAP_CYCLES cycles.
REQ-022 SHALL, at the end of GAP during boot, increment cfg_idx_o and go to LOAD if cfg_idx_o < NUM_WORDS-1; otherwise go to DONE.
REQ-023 SHALL, on DONE entry after boot, set radio_en_o=1 and done_o=1 (levels held until the next start_i or rst).
REQ-024 SHALL return to the originating state (IDLE or DONE) at the end of GAP for a host write.
REQ-025 SHALL drive busy_o = 1 in LOAD, SHIFT and GAP, and 0 otherwise.
REQ-026 SHALL keep spi_csn_o high and spi_sclk_o low in IDLE, LOAD, GAP and DONE.

Reset
REQ-027 SHALL, while rst is high, force state IDLE, spi_csn_o=1, spi_sclk_o=0, spi_sdata_o=0, radio_en_o=0, busy_o=0, done_o=0, cfg_idx_o=0 and all counters to 0.
REQ-028 SHALL, if reset occurs mid-frame, abort the frame immediately (CSn rises asynchronously) and send no partial frame after release.
REQ-029 SHALL hold wr_ready_o=1 in the first cycle after reset release when start_i=0.

Structure
REQ-030 SHALL place the boot table (NUM_WORDS x 28-bit defaults), MAX2769 register address constants, the frame width (32) and the FSM state enum in package radio_cfg_pkg.
REQ-031 SHALL implement the bit-level serializer (SCLK divider, 32-bit shift register, bit counter) as sub-module max2769_spi_shift, with load/done handshake to the FSM.

Verification
REQ-032 SHALL verify boot: CLK_DIV=4, GAP=16, NUM_WORDS=10, one start_i pulse -> 10 CSn-low windows of 256 cycles each, with decoded addresses 0..9 and data matching the table; radio_en_o rises exactly 10*273 cycles after LOAD entry.
REQ-033 SHALL verify a host write in DONE: addr=0x3, data=0xEAFF1DC -> frame 0xEAFF1DC3 decoded on SCLK rising edges; radio_en_o stays 1; done_o stays 1.
REQ-034 SHALL verify simultaneous start_i and wr_valid_i in IDLE -> wr_ready_o=0, boot starts, and the host write is accepted only after DONE.
REQ-035 SHALL verify rst asserted at bit 17 of frame 4 -> CSn high in the same cycle, all outputs at reset values, and no SCLK edges until the next start_i.
REQ-036 SHALL verify start_i pulsed during SHIFT -> no effect (cfg_idx_o sequence unchanged, total frames = 10).
REQ-037 SHALL verify CLK_DIV=1 -> SCLK period is 2 cycles, 64-cycle CSn windows, and SDATA stable at every SCLK rising edge.

Source files
------------

// File: rtl/radio_cfg_pkg.sv
// Shared constants for the MAX2769 configuration block: frame layout,
// register addresses, the power-up register table and the controller states.
package radio_cfg_pkg;

  localparam int FRAME_W   = 32;
  localparam int DATA_W    = 28;
  localparam int ADDR_W    = 4;
  localparam int MAX_WORDS = 16;

  localparam logic [ADDR_W-1:0] ADDR_CONF1   = 4'h0;
  localparam logic [ADDR_W-1:0] ADDR_CONF2   = 4'h1;
  localparam logic [ADDR_W-1:0] ADDR_CONF3   = 4'h2;
  localparam logic [ADDR_W-1:0] ADDR_PLLCONF = 4'h3;
  localparam logic [ADDR_W-1:0] ADDR_DIV     = 4'h4;
  localparam logic [ADDR_W-1:0] ADDR_FDIV    = 4'h5;
  localparam logic [ADDR_W-1:0] ADDR_STRM    = 4'h6;
  localparam logic [ADDR_W-1:0] ADDR_CLK     = 4'h7;
  localparam logic [ADDR_W-1:0] ADDR_TEST1   = 4'h8;
  localparam logic [ADDR_W-1:0] ADDR_TEST2   = 4'h9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_e;

  // Boot word i is written to register address i; unused slots stay zero.
  localparam logic [DATA_W-1:0] BOOT_TABLE [MAX_WORDS] = '{
    28'hA2919A3, 28'h0550288, 28'hEAFF1DC, 28'h9EC0008,
    28'h0C00080, 28'h8000070, 28'h8000000, 28'h10061B2,
    28'h1E0F401, 28'h14C0402, 28'h0000000, 28'h0000000,
    28'h0000000, 28'h0000000, 28'h0000000, 28'h0000000
  };

  function automatic logic [FRAME_W-1:0] make_frame(input logic [DATA_W-1:0] data,
                                                    input logic [ADDR_W-1:0] addr);
    return {data, addr};
  endfunction

endpackage

// File: rtl/max2769_spi_shift.sv
// Bit-level serializer: loads a 32-bit frame, shifts it out MSB first with a
// divided SCLK and pulses done_o in the last cycle of the frame.
module max2769_spi_shift
  import radio_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               clk16,
  input  logic               rst,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] frame_i,
  output logic               sclk_o,
  output logic               sdata_o,
  output logic               active_o,
  output logic               done_o
);

  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [7:0]         div_q, div_d;
  logic [4:0]         bit_q, bit_d;
  logic               sclk_q, sclk_d;
  logic               active_q, active_d;
  logic               half_end;

  always_comb begin
    // NOTE: every _d takes its _q value first so no path through this block can infer a latch.
    shift_d  = shift_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    active_d = active_q;
    half_end = active_q && (div_q == 8'(CLK_DIV - 1));
    done_o   = half_end && sclk_q && (bit_q == 5'd31);

    if (load_i) begin
      shift_d  = frame_i;
      div_d    = '0;
      bit_d    = '0;
      sclk_d   = 1'b0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (half_end) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
        // Data advances on the falling edge so it is stable across the rising edge.
        if (sclk_q) begin
          shift_d = {shift_q[FRAME_W-2:0], 1'b0};
          bit_d   = bit_q + 5'd1;
          if (done_o) active_d = 1'b0;
        end
      end else begin
        div_d = div_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk16 or posedge rst) begin
    if (rst) begin
      shift_q  <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop updates from the values present before the edge.
      shift_q  <= shift_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      active_q <= active_d;
    end
  end

  assign sclk_o   = sclk_q;
  assign sdata_o  = shift_q[FRAME_W-1];
  assign active_o = active_q;

endmodule

// File: rtl/radio_config.sv
// MAX2769 configuration controller: streams the boot table after start_i,
// then enables the radio; also forwards single host register writes.
module radio_config
  import radio_cfg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int NUM_WORDS  = 10,
  parameter int GAP_CYCLES = 16
) (
  input  logic              clk16,
  input  logic              rst,
  input  logic              start_i,
  input  logic              wr_valid_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  output logic              spi_sclk_o,
  output logic              spi_sdata_o,
  output logic              spi_csn_o,
  output logic              radio_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [3:0]        cfg_idx_o
);

  state_e              state_q, state_d;
  logic [3:0]          cfg_idx_q, cfg_idx_d;
  logic [7:0]          gap_q, gap_d;
  logic                host_q, host_d;
  logic                ret_done_q, ret_done_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                radio_en_q, radio_en_d;

  logic                sh_load;
  logic                sh_done;
  logic                sh_active;
  logic [FRAME_W-1:0]  frame;

  assign wr_ready_o = ((state_q == S_IDLE) || (state_q == S_DONE)) && !start_i;
  assign busy_o     = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_GAP);

  always_comb begin
    state_d    = state_q;
    cfg_idx_d  = cfg_idx_q;
    gap_d      = gap_q;
    host_d     = host_q;
    ret_done_d = ret_done_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = done_q;
    radio_en_d = radio_en_q;
    sh_load    = 1'b0;
    frame      = host_q ? make_frame(wr_data_q, wr_addr_q)
                        : make_frame(BOOT_TABLE[cfg_idx_q], cfg_idx_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          done_d     = 1'b0;
          radio_en_d = 1'b0;
          cfg_idx_d  = '0;
          host_d     = 1'b0;
          state_d    = S_LOAD;
        end else if (wr_valid_i) begin
          wr_addr_d  = wr_addr_i;
          wr_data_d  = wr_data_i;
          host_d     = 1'b1;
          ret_done_d = (state_q == S_DONE);
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        sh_load = 1'b1;
        gap_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (sh_done) state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == 8'(GAP_CYCLES - 1)) begin
          gap_d = '0;
          if (host_q) begin
            host_d  = 1'b0;
            state_d = ret_done_q ? S_DONE : S_IDLE;
          end else if (cfg_idx_q < 4'(NUM_WORDS - 1)) begin
            cfg_idx_d = cfg_idx_q + 4'd1;
            state_d   = S_LOAD;
          end else begin
            radio_en_d = 1'b1;
            done_d     = 1'b1;
            state_d    = S_DONE;
          end
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk16 or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cfg_idx_q  <= '0;
      gap_q      <= '0;
      host_q     <= 1'b0;
      ret_done_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      radio_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_idx_q  <= cfg_idx_d;
      gap_q      <= gap_d;
      host_q     <= host_d;
      ret_done_q <= ret_done_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      radio_en_q <= radio_en_d;
    end
  end

  max2769_spi_shift #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk16    (clk16),
    .rst      (rst),
    .load_i   (sh_load),
    .frame_i  (frame),
    .sclk_o   (spi_sclk_o),
    .sdata_o  (spi_sdata_o),
    .active_o (sh_active),
    .done_o   (sh_done)
  );

  // Reset clears the shifter asynchronously, so CSn rises without waiting for a clock.
  assign spi_csn_o  = ~sh_active;
  assign radio_en_o = radio_en_q;
  assign done_o     = done_q;
  assign cfg_idx_o  = cfg_idx_q;

endmodule

// File: tb/tb_radio_config.sv
// Self-checking bench for radio_config: an SPI monitor decodes frames and
// compares them with a scoreboard queue; a second instance runs CLK_DIV=1.
module tb_radio_config;

  logic clk16 = 1'b0;
  always #5 clk16 = ~clk16;

  // Main instance (defaults)
  logic        rst, start, wr_valid;
  logic [3:0]  wr_addr;
  logic [27:0] wr_data;
  logic        wr_ready, spi_sclk, spi_sdata, spi_csn, radio_en, busy, done;
  logic [3:0]  cfg_idx;

  // Fast instance: CLK_DIV=1, three words, one gap cycle
  logic        rst1, start1, wr_valid1;
  logic [3:0]  wr_addr1;
  logic [27:0] wr_data1;
  logic        wr_ready1, spi_sclk1, spi_sdata1, spi_csn1, radio_en1, busy1, done1;
  logic [3:0]  cfg_idx1;

  radio_config dut (
    .clk16(clk16), .rst(rst), .start_i(start), .wr_valid_i(wr_valid),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .spi_sclk_o(spi_sclk), .spi_sdata_o(spi_sdata), .spi_csn_o(spi_csn),
    .radio_en_o(radio_en), .busy_o(busy), .done_o(done), .cfg_idx_o(cfg_idx)
  );

  radio_config #(.CLK_DIV(1), .NUM_WORDS(3), .GAP_CYCLES(1)) dut1 (
    .clk16(clk16), .rst(rst1), .start_i(start1), .wr_valid_i(wr_valid1),
    .wr_addr_i(wr_addr1), .wr_data_i(wr_data1), .wr_ready_o(wr_ready1),
    .spi_sclk_o(spi_sclk1), .spi_sdata_o(spi_sdata1), .spi_csn_o(spi_csn1),
    .radio_en_o(radio_en1), .busy_o(busy1), .done_o(done1), .cfg_idx_o(cfg_idx1)
  );

  // Independent copy of the MAX2769 power-up words
  localparam logic [27:0] TBL [10] = '{
    28'hA2919A3, 28'h0550288, 28'hEAFF1DC, 28'h9EC0008, 28'h0C00080,
    28'h8000070, 28'h8000000, 28'h10061B2, 28'h1E0F401, 28'h14C0402
  };
  localparam int DIV [2] = '{4, 1};

  function automatic logic [31:0] boot_frame(input int i);
    logic [27:0] d;
    d = TBL[i];
    return {d, 4'(i)};
  endfunction

  typedef struct {
    logic [3:0]  addr;
    logic [27:0] data;
    logic [31:0] frame;
  } host_vec_t;

  host_vec_t vecs [4];

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk16) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- SPI monitor / scoreboard ----------------
  logic [31:0] exp0_q [$];
  logic [31:0] exp1_q [$];
  logic [3:0]  idx_log [$];

  logic        p_csn  [2] = '{1'b1, 1'b1};
  logic        p_sclk [2] = '{1'b0, 1'b0};
  logic        p_sd   [2] = '{1'b0, 1'b0};
  logic [31:0] sh     [2];
  int          nbits  [2] = '{0, 0};
  int          win    [2] = '{0, 0};
  int          last_rise [2];
  logic        per_ok [2];
  logic        stab_ok[2];
  int          rises  [2] = '{0, 0};
  int          falls  [2] = '{0, 0};
  int          frames [2] = '{0, 0};

  task automatic close_frame(input int c);
    logic [31:0] e;
    check($sformatf("ch%0d frame bit count", c), 32'(nbits[c]), 32'd32);
    check($sformatf("ch%0d CSn window length", c), 32'(win[c]), 32'(64 * DIV[c]));
    check($sformatf("ch%0d SCLK period", c), 32'(per_ok[c]), 32'd1);
    check($sformatf("ch%0d SDATA stable at SCLK rise", c), 32'(stab_ok[c]), 32'd1);
    if ((c == 0 && exp0_q.size() == 0) || (c == 1 && exp1_q.size() == 0)) begin
      n_vec++;
      n_fail++;
      $display("FAIL ch%0d unexpected frame: got 0x%08h, required none", c, sh[c]);
    end else begin
      e = (c == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
      check($sformatf("ch%0d decoded frame", c), sh[c], e);
    end
    frames[c]++;
  endtask

  always @(negedge clk16) begin : mon
    logic csn, sclk, sd, r;
    for (int c = 0; c < 2; c++) begin
      csn  = (c == 0) ? spi_csn   : spi_csn1;
      sclk = (c == 0) ? spi_sclk  : spi_sclk1;
      sd   = (c == 0) ? spi_sdata : spi_sdata1;
      r    = (c == 0) ? rst       : rst1;
      if (!csn) begin
        if (p_csn[c]) begin
          win[c]     = 0;
          nbits[c]   = 0;
          sh[c]      = '0;
          per_ok[c]  = 1'b1;
          stab_ok[c] = 1'b1;
          falls[c]++;
          if (c == 0) idx_log.push_back(cfg_idx);
        end
        win[c]++;
        if (sclk && !p_sclk[c]) begin
          rises[c]++;
          if (nbits[c] != 0 && (cyc - last_rise[c]) != 2 * DIV[c]) per_ok[c] = 1'b0;
          if (sd != p_sd[c]) stab_ok[c] = 1'b0;
          last_rise[c] = cyc;
          sh[c]        = {sh[c][30:0], sd};
          nbits[c]++;
        end
      end else begin
        if (sclk && !p_sclk[c]) rises[c]++;
        // A window closed by reset is an aborted frame, not a delivered one.
        if (!p_csn[c] && !r) close_frame(c);
      end
      p_csn[c]  = csn;
      p_sclk[c] = sclk;
      p_sd[c]   = sd;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_idle(input int limit, output logic ok, output logic en_held);
    ok      = 1'b0;
    en_held = 1'b1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk16);
      if (!radio_en) en_held = 1'b0;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int limit, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk16);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic ok, en_ok;
    int t0, t_en, f0, r0, fl0;

    vecs[0] = '{addr: 4'h3, data: 28'hEAFF1DC, frame: 32'hEAFF1DC3};
    vecs[1] = '{addr: 4'hF, data: 28'hFFFFFFF, frame: 32'hFFFFFFFF};
    vecs[2] = '{addr: 4'h0, data: 28'h0000000, frame: 32'h00000000};
    vecs[3] = '{addr: 4'hA, data: 28'h5A5A5A5, frame: 32'h5A5A5A5A};

    rst = 1'b1; start = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rst1 = 1'b1; start1 = 1'b0; wr_valid1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;
    repeat (3) @(negedge clk16);

    // Reset state
    check("reset csn", 32'(spi_csn), 32'd1);
    check("reset sclk", 32'(spi_sclk), 32'd0);
    check("reset sdata", 32'(spi_sdata), 32'd0);
    check("reset radio_en", 32'(radio_en), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset cfg_idx", 32'(cfg_idx), 32'd0);
    rst = 1'b0; rst1 = 1'b0;
    #1 check("wr_ready after reset release", 32'(wr_ready), 32'd1);
    @(negedge clk16);

    // Boot with a simultaneous host write held pending until DONE
    for (int i = 0; i < 10; i++) exp0_q.push_back(boot_frame(i));
    exp0_q.push_back(32'h12345675);
    start = 1'b1; wr_valid = 1'b1; wr_addr = 4'h5; wr_data = 28'h1234567;
    t0 = cyc + 1;
    #1 check("wr_ready low with start", 32'(wr_ready), 32'd0);
    @(negedge clk16);
    start = 1'b0;
    check("busy after start", 32'(busy), 32'd1);
    check("cfg_idx after start", 32'(cfg_idx), 32'd0);
    ok = 1'b0; t_en = -1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk16);
      if (radio_en && t_en < 0) t_en = cyc;
      if (wr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("boot reaches ready", 32'(ok), 32'd1);
    check("done when write accepted", 32'(done), 32'd1);
    check("radio_en delay from LOAD", 32'(t_en - t0), 32'd2730);
    @(negedge clk16);
    wr_valid = 1'b0;
    check("busy with pending host write", 32'(busy), 32'd1);
    wait_idle(400, ok, en_ok);
    check("pending write completes", 32'(ok), 32'd1);
    check("radio_en held over pending write", 32'(en_ok), 32'd1);
    check("cfg_idx after boot", 32'(cfg_idx), 32'd9);

    // Host writes from DONE
    for (int v = 0; v < 4; v++) begin
      exp0_q.push_back(vecs[v].frame);
      wr_addr = vecs[v].addr; wr_data = vecs[v].data; wr_valid = 1'b1;
      #1 check($sformatf("vec%0d wr_ready", v), 32'(wr_ready), 32'd1);
      @(negedge clk16);
      wr_valid = 1'b0;
      check($sformatf("vec%0d busy", v), 32'(busy), 32'd1);
      wait_idle(400, ok, en_ok);
      check($sformatf("vec%0d completes", v), 32'(ok), 32'd1);
      check($sformatf("vec%0d radio_en held", v), 32'(en_ok), 32'd1);
      check($sformatf("vec%0d done held", v), 32'(done), 32'd1);
      check($sformatf("vec%0d cfg_idx kept", v), 32'(cfg_idx), 32'd9);
    end
    check("all host frames seen", 32'(exp0_q.size()), 32'd0);

    // Reboot from DONE with a stray start_i during SHIFT
    idx_log.delete();
    f0 = frames[0];
    for (int i = 0; i < 10; i++) exp0_q.push_back(boot_frame(i));
    start = 1'b1;
    @(negedge clk16);
    start = 1'b0;
    check("reboot clears done", 32'(done), 32'd0);
    check("reboot clears radio_en", 32'(radio_en), 32'd0);
    check("reboot cfg_idx", 32'(cfg_idx), 32'd0);
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk16);
      if (cfg_idx == 4'd2 && !spi_csn) begin
        ok = 1'b1;
        break;
      end
    end
    check("reached frame 2 shift", 32'(ok), 32'd1);
    start = 1'b1;
    @(negedge clk16);
    start = 1'b0;
    check("start in SHIFT keeps cfg_idx", 32'(cfg_idx), 32'd2);
    check("start in SHIFT keeps csn low", 32'(spi_csn), 32'd0);
    wait_done(4000, ok);
    check("reboot done", 32'(ok), 32'd1);
    check("reboot frame count", 32'(frames[0] - f0), 32'd10);
    check("reboot index log size", 32'(idx_log.size()), 32'd10);
    ok = 1'b1;
    foreach (idx_log[i]) if (idx_log[i] != 4'(i)) ok = 1'b0;
    check("reboot index sequence", 32'(ok), 32'd1);
    check("reboot frames all seen", 32'(exp0_q.size()), 32'd0);

    // Reset at bit 17 of frame 4
    for (int i = 0; i < 10; i++) exp0_q.push_back(boot_frame(i));
    start = 1'b1;
    @(negedge clk16);
    start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk16);
      if (cfg_idx == 4'd4 && !spi_csn && nbits[0] == 17) begin
        ok = 1'b1;
        break;
      end
    end
    check("reached frame 4 bit 17", 32'(ok), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort csn immediate", 32'(spi_csn), 32'd1);
    check("abort sclk", 32'(spi_sclk), 32'd0);
    check("abort sdata", 32'(spi_sdata), 32'd0);
    check("abort radio_en", 32'(radio_en), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort cfg_idx", 32'(cfg_idx), 32'd0);
    repeat (3) @(negedge clk16);
    exp0_q.delete();
    r0 = rises[0]; fl0 = falls[0];
    rst = 1'b0;
    #1 check("wr_ready after abort release", 32'(wr_ready), 32'd1);
    repeat (600) @(negedge clk16);
    check("no SCLK edges after abort", 32'(rises[0] - r0), 32'd0);
    check("no CSn windows after abort", 32'(falls[0] - fl0), 32'd0);
    check("idle after abort", 32'(busy), 32'd0);

    // CLK_DIV=1 instance
    for (int i = 0; i < 3; i++) exp1_q.push_back(boot_frame(i));
    start1 = 1'b1;
    t0 = cyc + 1;
    @(negedge clk16);
    start1 = 1'b0;
    ok = 1'b0; t_en = -1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk16);
      if (radio_en1) begin
        ok = 1'b1;
        t_en = cyc;
        break;
      end
    end
    check("div1 boot completes", 32'(ok), 32'd1);
    check("div1 radio_en delay", 32'(t_en - t0), 32'd198);
    check("div1 frame count", 32'(frames[1]), 32'd3);
    check("div1 frames all seen", 32'(exp1_q.size()), 32'd0);
    check("div1 done", 32'(done1), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
